alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, registered successor to the combinational datapath ALU. Keeps the same
//  4-bit opcode map and adds a valid/ready handshake, status flags, and iterative
//  MUL/DIV/REM. Sits between operand fetch and writeback in the core.
//  Single-cycle ops run at one op per cycle. MUL/DIV/REM hold the unit busy.
// PARAMETERS
//  WIDTH   32  operand/result width; power of two, >= 8
//  SHW     $clog2(WIDTH)  shift-amount bits, derived; do not override
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      operands/opcode valid
//  in_ready    out  1      unit can accept an op this cycle
//  alu_op      in   4      opcode
//  bus_a       in   WIDTH  operand A
//  bus_b       in   WIDTH  operand B
//  out_valid   out  1      result valid
//  out_ready   in   1      consumer takes the result
//  out_result  out  WIDTH  result
//  out_zero    out  1      out_result == 0
//  out_neg     out  1      out_result[WIDTH-1]
//  out_carry   out  1      ADD: carry out; SUB: borrow (A<B unsigned); else 0
//  out_ovf     out  1      ADD/SUB: signed overflow; else 0
//  out_dbz     out  1      DIV/REM with B==0; else 0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, all out_* data/flags=0, iteration counter=0.
//  Reset mid-op aborts the op with no result. in_ready=1 after release.
//  Accept = in_valid & in_ready. Operands and opcode are latched on accept. Bus changes
//  after accept have no effect.
//  States:
//   - IDLE: in_ready=1. Accept single-cycle op -> DONE. Accept MUL/DIV/REM -> BUSY.
//   - BUSY: in_ready=0. One iteration per cycle. After WIDTH iterations -> DONE.
//   - DONE: out_valid=1. Outputs hold while out_ready=0.
//     in_ready = out_ready, so the unit takes back-to-back ops.
//     On out_ready: accept a new single-cycle op -> DONE with the new result;
//     accept MUL/DIV/REM -> BUSY; no accept -> IDLE.
//  Latency (accept at cycle 0):
//   - single-cycle ops: out_valid at cycle 1.
//   - MUL/DIV/REM: out_valid at cycle WIDTH+1.
//  Opcodes (unsigned unless stated):
//   0000 A&B; 0001 A|B; 0010 A^B; 0011 ~A; 0100 A+B; 0101 A-B;
//   0110 (A>B)?1:0; 1010 A<<B[SHW-1:0]; 1011 A>>B[SHW-1:0] (logical);
//   1101 B<<(WIDTH/2); 0111 MUL low WIDTH bits; 1000 DIV quotient; 1001 REM;
//   others -> result 0, all flags 0, single-cycle (NOP).
//  Arithmetic wraps modulo 2^WIDTH.
//  MUL is shift-add. DIV/REM use restoring division, one bit per cycle.
//  Divide by zero: still WIDTH cycles. DIV -> all-ones, REM -> A, out_dbz=1.
//  Flags are computed from the final result and registered together with out_result.
// CONFIGURATION
//  ALU_MULDIV_EN defined: MUL/DIV/REM behave as above; BUSY state and counter are present.
//  ALU_MULDIV_EN undefined: opcodes 0111/1000/1001 are NOPs (single-cycle, result 0,
//  out_dbz never set). BUSY state, counter and mul/div datapath are not built.
// TESTING (WIDTH=32)
//  T1 reset: rst_n=0 mid-MUL at cycle 10 -> out_valid=0 and outputs 0 at once;
//     after release in_ready=1 and no stale result appears.
//  T2 back-to-back: ADD 0xFFFFFFFF+1, then SUB 3-5, out_ready=1 each cycle:
//     - ADD -> result 0, zero=1, carry=1.
//     - SUB -> 0xFFFFFFFE, neg=1, carry=1.
//     - Valid on consecutive cycles.
//  T3 ovf/shift: ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1.
//     SHL 1 by B=0x21 -> 0x2 (B[4:0]=1). LUI B=0x1234 -> 0x12340000.
//  T4 backpressure: op accepted, out_ready=0 for 5 cycles -> result/flags stable,
//     in_ready=0, in_valid ignored; out_ready=1 -> released.
//  T5 MUL/DIV (ALU_MULDIV_EN): MUL 0x10000*0x10001 -> 0x00010000 at cycle 33.
//     DIV 100/7 -> 14; REM -> 2. in_ready=0 during BUSY.
//  T6 div0/NOP: DIV 5/0 -> 0xFFFFFFFF, dbz=1; REM 5/0 -> 5, dbz=1.
//     Opcode 1111 -> 0 at cycle 1. Without ALU_MULDIV_EN, MUL 3*4 -> 0 at cycle 1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready handshake and status flags.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready input handshake; opcode and operands latched on accept
//   alu_op            4-bit opcode (same map as the combinational datapath ALU)
//   bus_a, bus_b      WIDTH-bit operands
//   out_valid/out_ready output handshake; result and flags hold while stalled
//   out_result        WIDTH-bit result
//   out_zero/out_neg/out_carry/out_ovf/out_dbz  status flags registered with out_result
//   dbg_state         current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready does not depend on in_valid, and out_valid does not depend on
// out_ready, so neither side can form a combinational loop through this unit.
//
// Build option ALU_MULDIV_EN: when defined, opcodes 0111/1000/1001 run an
// iterative shift-add multiply or restoring divide (WIDTH cycles in BUSY).
// When undefined those opcodes are single-cycle NOPs and no BUSY logic exists.

module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] bus_a,
    input  logic [WIDTH-1:0] bus_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_dbz,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
`ifdef ALU_MULDIV_EN
    localparam logic [1:0] BUSY = 2'd1;
`endif
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic       accept;
    logic       load_sc;
    logic [1:0] accept_state;

    // Single-cycle datapath, evaluated straight from the input buses.
    logic [WIDTH:0]   add_x, sub_x;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry, sc_ovf;

    always_comb begin
        add_x    = {1'b0, bus_a} + {1'b0, bus_b};
        sub_x    = {1'b0, bus_a} - {1'b0, bus_b};
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (alu_op)
            4'b0000: sc_res = bus_a & bus_b;
            4'b0001: sc_res = bus_a | bus_b;
            4'b0010: sc_res = bus_a ^ bus_b;
            4'b0011: sc_res = ~bus_a;
            4'b0100: begin
                sc_res   = add_x[WIDTH-1:0];
                sc_carry = add_x[WIDTH];
                sc_ovf   = (bus_a[WIDTH-1] == bus_b[WIDTH-1]) &&
                           (add_x[WIDTH-1] != bus_a[WIDTH-1]);
            end
            4'b0101: begin
                sc_res   = sub_x[WIDTH-1:0];
                sc_carry = sub_x[WIDTH];   // borrow: A < B unsigned
                sc_ovf   = (bus_a[WIDTH-1] != bus_b[WIDTH-1]) &&
                           (sub_x[WIDTH-1] != bus_a[WIDTH-1]);
            end
            4'b0110: sc_res = {{(WIDTH-1){1'b0}}, (bus_a > bus_b)};
            4'b1010: sc_res = bus_a << bus_b[SHW-1:0];
            4'b1011: sc_res = bus_a >> bus_b[SHW-1:0];
            4'b1101: sc_res = bus_b << (WIDTH/2);
            default: sc_res = '0;
        endcase
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign dbg_state = state_q;
    assign accept    = in_valid && in_ready;

`ifdef ALU_MULDIV_EN
    // Iterative multiply/divide. x_q holds the multiplicand (MUL) or the
    // dividend shifting into the quotient (DIV/REM); y_q holds the multiplier
    // or divisor; acc_q holds the partial product or partial remainder.
    logic [3:0]       op_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] acc_q, x_q, y_q;
    logic [WIDTH-1:0] acc_n, x_n, y_n, long_res;
    logic [WIDTH:0]   shifted, diff;
    logic             ge, is_mul, start_long, last_iter, long_dbz;

    assign start_long = (alu_op == 4'b0111) || (alu_op == 4'b1000) || (alu_op == 4'b1001);
    assign is_mul     = (op_q == 4'b0111);
    assign last_iter  = (state_q == BUSY) && (cnt_q == SHW'(WIDTH-1));
    assign long_dbz   = !is_mul && (y_q == '0);

    always_comb begin
        shifted = {acc_q, x_q[WIDTH-1]};
        diff    = shifted - {1'b0, y_q};
        // A zero divisor always compares as "fits", which naturally yields an
        // all-ones quotient and a remainder equal to the dividend.
        ge      = (shifted >= {1'b0, y_q});
        if (is_mul) begin
            acc_n = y_q[0] ? (acc_q + x_q) : acc_q;
            x_n   = x_q << 1;
            y_n   = y_q >> 1;
        end else begin
            acc_n = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            x_n   = {x_q[WIDTH-2:0], ge};
            y_n   = y_q;
        end
        if (op_q == 4'b1000) long_res = x_n;
        else                 long_res = acc_n;
    end

    assign load_sc      = accept && !start_long;
    assign accept_state = start_long ? BUSY : DONE;
`else
    assign load_sc      = accept;
    assign accept_state = DONE;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = accept_state;
`ifdef ALU_MULDIV_EN
            BUSY: if (last_iter) state_d = DONE;
`endif
            DONE: if (out_ready) state_d = accept ? accept_state : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_zero   <= 1'b0;
            out_neg    <= 1'b0;
            out_carry  <= 1'b0;
            out_ovf    <= 1'b0;
            out_dbz    <= 1'b0;
`ifdef ALU_MULDIV_EN
            op_q  <= '0;
            cnt_q <= '0;
            acc_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
`endif
        end else begin
            if (load_sc) begin
                out_result <= sc_res;
                out_zero   <= (sc_res == '0);
                out_neg    <= sc_res[WIDTH-1];
                out_carry  <= sc_carry;
                out_ovf    <= sc_ovf;
                out_dbz    <= 1'b0;
            end
`ifdef ALU_MULDIV_EN
            if (accept && start_long) begin
                op_q  <= alu_op;
                cnt_q <= '0;
                acc_q <= '0;
                x_q   <= bus_a;
                y_q   <= bus_b;
            end
            if (state_q == BUSY) begin
                acc_q <= acc_n;
                x_q   <= x_n;
                y_q   <= y_n;
                cnt_q <= cnt_q + SHW'(1);
                if (last_iter) begin
                    out_result <= long_res;
                    out_zero   <= (long_res == '0);
                    out_neg    <= long_res[WIDTH-1];
                    out_carry  <= 1'b0;
                    out_ovf    <= 1'b0;
                    out_dbz    <= long_dbz;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int W  = 32;
    localparam int EW = W + 5;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_op;
    logic [W-1:0] bus_a, bus_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero, out_neg, out_carry, out_ovf, out_dbz;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .bus_a(bus_a), .bus_b(bus_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result),
        .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry),
        .out_ovf(out_ovf), .out_dbz(out_dbz),
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: {result, zero, neg, carry, ovf, dbz}
    function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v, d;
        r = '0; c = 1'b0; v = 1'b0; d = 1'b0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a ^ b;
            4'h3: r = ~a;
            4'h4: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'h5: begin
                r = a - b;
                c = (a < b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'h6: r = (a > b) ? 1 : 0;
            4'hA: r = a << (b % W);
            4'hB: r = a >> (b % W);
            4'hD: r = b << (W / 2);
`ifdef ALU_MULDIV_EN
            4'h7: r = a * b;
            4'h8: begin
                if (b == 0) begin r = '1; d = 1'b1; end
                else r = a / b;
            end
            4'h9: begin
                if (b == 0) begin r = a; d = 1'b1; end
                else r = a % b;
            end
`endif
            default: r = '0;
        endcase
        return {r, (r == '0), r[W-1], c, v, d};
    endfunction

    function automatic bit is_long(input logic [3:0] op);
`ifdef ALU_MULDIV_EN
        return (op == 4'h7) || (op == 4'h8) || (op == 4'h9);
`else
        return (op == 4'hF) && (op == 4'h0);
`endif
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("stale_result_valid", out_valid, 1'b0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", out_result, mon_exp[EW-1:5]);
                check("flags", {out_zero, out_neg, out_carry, out_ovf, out_dbz}, mon_exp[4:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called and returns at 1 time unit after a rising edge.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int waited = 0;
        in_valid = 1'b1; alu_op = op; bus_a = a; bus_b = b;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
        else exp_q.push_back(model(op, a, b));
        @(posedge clk); #1;
        // Scramble the buses: the unit must work from its latched copy.
        in_valid = 1'b0;
        alu_op   = 4'($urandom);
        bus_a    = $urandom;
        bus_b    = $urandom;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_long_latency();
        for (int i = 1; i <= W; i++) begin
            check("busy_out_valid", out_valid, 1'b0);
            check("busy_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        check("long_latency_valid", out_valid, 1'b1);
    endtask

    logic [EW-1:0] hold_exp;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; bus_a = '0; bus_b = '0;
        #12;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_result", out_result, '0);
        check("reset_flags", {out_zero, out_neg, out_carry, out_ovf, out_dbz}, 5'b0);
        check("reset_state", dbg_state, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("reset_in_ready", in_ready, 1'b1);

        // T1: reset while an op is in flight (or held) aborts it
`ifdef ALU_MULDIV_EN
        send(4'h7, 32'd3, 32'd4);
`else
        send(4'h4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`endif
        repeat (9) begin @(posedge clk); #1; end
        #3 rst_n = 1'b0;
        #1;
        check("t1_abort_valid", out_valid, 1'b0);
        check("t1_abort_result", out_result, '0);
        check("t1_abort_flags", {out_zero, out_neg, out_carry, out_ovf, out_dbz}, 5'b0);
        check("t1_abort_state", dbg_state, 2'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("t1_in_ready", in_ready, 1'b1);
        for (int i = 0; i < W + 4; i++) begin
            check("t1_no_stale", out_valid, 1'b0);
            @(posedge clk); #1;
        end

        // T2: back-to-back ADD and SUB
        send(4'h4, 32'hFFFF_FFFF, 32'h1);
        check("t2_add_latency", out_valid, 1'b1);
        send(4'h5, 32'd3, 32'd5);
        check("t2_sub_consecutive", out_valid, 1'b1);

        // T3: overflow, shift amount masking, upper-half load
        send(4'h4, 32'h7FFF_FFFF, 32'h1);
        send(4'hA, 32'h1, 32'h21);
        send(4'hD, 32'h0, 32'h1234);
        send(4'h6, 32'd9, 32'd2);
        send(4'hB, 32'h8000_0000, 32'h3F);
        send(4'h3, 32'h0F0F_0F0F, 32'h0);
        drain();

        // T4: backpressure holds result, blocks input
        out_ready = 1'b0;
        hold_exp  = model(4'h2, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
        send(4'h2, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", out_valid, 1'b1);
            check("t4_hold_result", out_result, hold_exp[EW-1:5]);
            check("t4_hold_flags", {out_zero, out_neg, out_carry, out_ovf, out_dbz}, hold_exp[4:0]);
            check("t4_in_ready", in_ready, 1'b0);
            in_valid = 1'b1; alu_op = 4'h4; bus_a = $urandom; bus_b = $urandom;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_released", out_valid, 1'b0);

        // T5: multiply / divide / remainder
        send(4'h7, 32'h1_0000, 32'h1_0001);
        if (is_long(4'h7)) check_long_latency();
        else check("t5_mul_nop_latency", out_valid, 1'b1);
        send(4'h8, 32'd100, 32'd7);
        send(4'h9, 32'd100, 32'd7);
        drain();

        // T6: divide by zero, unused opcode, MUL as NOP
        send(4'h8, 32'd5, 32'd0);
        send(4'h9, 32'd5, 32'd0);
        drain();
        send(4'hF, 32'd3, 32'd4);
        check("t6_nop_latency", out_valid, 1'b1);
        send(4'h7, 32'd3, 32'd4);
        if (is_long(4'h7)) check_long_latency();
        else check("t6_mul_nop_latency", out_valid, 1'b1);
        drain();

        // Random mix with idle gaps
        for (int i = 0; i < 24; i++) begin
            send(4'($urandom_range(0, 15)), $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        drain();
        repeat (3) begin @(posedge clk); #1; end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
